// File: rtl/proc_mem_pkg.sv
// rtl/proc_mem_pkg.sv - shared types and widths for the processor memory port
package proc_mem_pkg;

    localparam int WORD_W     = 16;
    localparam int MEM_ADDR_W = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE   = 3'd3,
        HALTED = 3'd4
    } arb_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data stages
module mem_port_arbiter
    import proc_mem_pkg::*;
#(
    parameter int STARVE_MAX = 2,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  halt,
    input  logic                  i_req,
    input  logic [MEM_ADDR_W-1:0] i_addr,
    output logic                  i_done,
    output logic [WORD_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_wr,
    input  logic [MEM_ADDR_W-1:0] d_addr,
    input  logic [WORD_W-1:0]     d_wdata,
    output logic                  d_done,
    output logic [WORD_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_en,
    output logic                  mem_wr,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0]     mem_wdata,
    input  logic                  mem_done,
    input  logic [WORD_W-1:0]     mem_rdata,
    output logic                  halted,
    output logic [CNT_W-1:0]      i_grant_cnt,
    output logic [CNT_W-1:0]      d_grant_cnt
);

    arb_state_t            state_q, state_d;
    logic [2:0]            starve_q;
    logic                  halt_pend_q;
    logic                  mem_en_q, mem_wr_q;
    logic [MEM_ADDR_W-1:0] mem_addr_q;
    logic [WORD_W-1:0]     mem_wdata_q;
    logic                  i_done_q, d_done_q, d_err_q, halted_q;
    logic [WORD_W-1:0]     i_rdata_q, d_rdata_q;
    logic                  grant_i, grant_d, misalign;
    logic                  fetch_starved;

    assign fetch_starved = i_req && (starve_q == 3'(STARVE_MAX));

    always_comb begin
        state_d  = state_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        misalign = 1'b0;
        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = HALTED;
                end else if (d_req && d_addr[0]) begin
                    grant_d  = 1'b1;
                    misalign = 1'b1;
                    state_d  = DONE;
                end else if (d_req && !fetch_starved) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_done) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = (halt_pend_q || halt) ? HALTED : IDLE;
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            halt_pend_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mem_en_q <= grant_i || (grant_d && !misalign);
            if (grant_i || (grant_d && !misalign)) begin
                mem_wr_q    <= grant_d && d_wr;
                mem_addr_q  <= grant_d ? d_addr : i_addr;
                mem_wdata_q <= grant_d ? d_wdata : '0;
            end
            // Errored data grants still count against the waiting fetch.
            if (grant_i) begin
                starve_q <= '0;
            end else if (grant_d) begin
                starve_q <= i_req ? starve_q + 3'd1 : 3'd0;
            end
            if (halt && (state_q == BUSY_I || state_q == BUSY_D)) begin
                halt_pend_q <= 1'b1;
            end
            i_done_q <= (state_q == BUSY_I) && mem_done;
            d_done_q <= ((state_q == BUSY_D) && mem_done) || misalign;
            d_err_q  <= misalign;
            if ((state_q == BUSY_I) && mem_done) begin
                i_rdata_q <= mem_rdata;
            end
            if ((state_q == BUSY_D) && mem_done && !mem_wr_q) begin
                d_rdata_q <= mem_rdata;
            end
            halted_q <= (state_d == HALTED);
        end
    end

    sat_counter #(.W(CNT_W)) u_i_cnt (
        .clk (clk),
        .rst (rst),
        .inc (grant_i),
        .cnt (i_grant_cnt)
    );

    sat_counter #(.W(CNT_W)) u_d_cnt (
        .clk (clk),
        .rst (rst),
        .inc (grant_d),
        .cnt (d_grant_cnt)
    );

    assign mem_en    = mem_en_q;
    assign mem_wr    = mem_wr_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign i_done    = i_done_q;
    assign i_rdata   = i_rdata_q;
    assign d_done    = d_done_q;
    assign d_rdata   = d_rdata_q;
    assign d_err     = d_err_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import proc_mem_pkg::*;

    logic        clk, rst, halt;
    logic        i_req, i_done, d_req, d_wr, d_done, d_err;
    logic [15:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_wr, mem_done, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  i_grant_cnt, d_grant_cnt;
    logic [77:0] outs;

    mem_port_arbiter #(.STARVE_MAX(2), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .halt(halt),
        .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .halted(halted), .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
    );

    assign outs = {i_done, i_rdata, d_done, d_rdata, d_err, mem_en, mem_wr,
                   mem_addr, mem_wdata, halted, i_grant_cnt, d_grant_cnt};

    typedef struct {
        bit          is_d;
        bit          err;
        bit          chk;
        logic [15:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_err = 0;
    int          done_cnt = 0;
    int          mem_en_cnt = 0;
    int          cyc = 0;
    int          prev_done_cyc = 0;
    int          last_gap = 0;
    int          max_starve = 0;
    int          lat = 1;
    logic [15:0] mem [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [79:0] got, logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: responds L cycles after mem_en, deliberately ignores rst.
    initial begin
        logic [15:0] a, wd;
        logic        w;
        for (int k = 0; k < 256; k++) mem[k] = 16'h1000 + 16'(k);
        mem[8]  = 16'hA5A5;
        mem[16] = 16'hD00D;
        mem[32] = 16'h1A1A;
        mem_done  = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                a  = mem_addr;
                w  = mem_wr;
                wd = mem_wdata;
                repeat (lat) @(posedge clk);
                #1;
                mem_done  = 1'b1;
                mem_rdata = w ? 16'h0 : mem[a[8:1]];
                if (w) mem[a[8:1]] = wd;
                @(posedge clk);
                #1;
                mem_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (mem_en) mem_en_cnt++;
        if (32'(dut.starve_q) > max_starve) max_starve = 32'(dut.starve_q);
        if (!rst && d_err && !d_done) check("err_without_done", d_err, 1'b0);
        if (!rst && (i_done || d_done)) begin
            done_cnt++;
            last_gap = cyc - prev_done_cyc;
            prev_done_cyc = cyc;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_done i_done=%0b d_done=%0b required none", i_done, d_done);
            end else begin
                e = exp_q.pop_front();
                check("done_side_d", d_done, e.is_d);
                check("done_side_i", i_done, !e.is_d);
                check("done_err", d_err, e.err);
                if (e.chk) check("done_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    task automatic push(bit is_d, bit err, bit chk, logic [15:0] rdata);
        exp_t e;
        e.is_d = is_d; e.err = err; e.chk = chk; e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    task automatic wait_dones(int target, int budget);
        int k = 0;
        while (done_cnt < target && k < budget) begin
            tick();
            k++;
        end
        if (done_cnt < target) check("done_timeout", 80'(done_cnt), 80'(target));
    endtask

    task automatic do_reset();
        rst = 1'b1; halt = 1'b0; i_req = 1'b0; d_req = 1'b0;
        d_wr = 1'b0; i_addr = '0; d_addr = '0; d_wdata = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic txn(bit is_d, bit wr, logic [15:0] addr, logic [15:0] wd);
        int target = done_cnt + 1;
        if (is_d) begin
            d_req = 1'b1; d_wr = wr; d_addr = addr; d_wdata = wd;
        end else begin
            i_req = 1'b1; i_addr = addr;
        end
        wait_dones(target, 40);
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        int base, target;
        do_reset();
        check("reset_outputs", outs, 0);
        check("reset_state", dut.state_q, IDLE);

        // single fetch, L=1
        base = mem_en_cnt;
        push(0, 0, 1, 16'hA5A5);
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        check("fetch_mem_en_c1", mem_en, 1'b1);
        check("fetch_mem_addr", mem_addr, 16'h0010);
        tick();
        check("fetch_no_done_c2", i_done, 1'b0);
        tick();
        check("fetch_done_c3", i_done, 1'b1);
        check("fetch_i_cnt", i_grant_cnt, 4'd1);
        tick();
        i_req = 1'b0;
        repeat (3) tick();
        check("fetch_mem_en_count", 80'(mem_en_cnt - base), 80'(1));

        // contention with STARVE_MAX=2: D D I D D I
        do_reset();
        max_starve = 0;
        push(1, 0, 1, 16'hD00D); push(1, 0, 1, 16'hD00D); push(0, 0, 1, 16'h1A1A);
        push(1, 0, 1, 16'hD00D); push(1, 0, 1, 16'hD00D); push(0, 0, 1, 16'h1A1A);
        target = done_cnt + 6;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        i_req = 1'b1; i_addr = 16'h0040;
        wait_dones(target, 60);
        i_req = 1'b0; d_req = 1'b0;
        repeat (3) tick();
        check("starve_peak", 80'(max_starve), 80'(2));
        check("starve_i_cnt", i_grant_cnt, 4'd2);
        check("starve_d_cnt", d_grant_cnt, 4'd4);

        // misaligned store
        do_reset();
        base = mem_en_cnt;
        push(1, 1, 0, 16'h0);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0101; d_wdata = 16'hBEEF;
        tick();
        check("misal_d_done_c1", d_done, 1'b1);
        check("misal_d_err_c1", d_err, 1'b1);
        check("misal_no_mem_en", mem_en, 1'b0);
        tick();
        d_req = 1'b0;
        check("misal_d_cnt", d_grant_cnt, 4'd1);
        repeat (3) tick();
        check("misal_mem_en_count", 80'(mem_en_cnt - base), 80'(0));

        // aligned store then load-back
        push(1, 0, 0, 16'h0);
        txn(1, 1, 16'h0030, 16'h1234);
        push(1, 0, 1, 16'h1234);
        txn(1, 0, 16'h0030, 16'h0);
        tick();

        // halt during BUSY_D, L=3
        do_reset();
        lat = 3;
        base = mem_en_cnt;
        push(1, 0, 1, 16'hD00D);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        tick();
        check("halt_mem_en_c1", mem_en, 1'b1);
        tick();
        halt = 1'b1;
        repeat (3) tick();
        check("halt_d_done_c5", d_done, 1'b1);
        tick();
        d_req = 1'b0;
        check("halt_halted_c6", halted, 1'b1);
        i_req = 1'b1; i_addr = 16'h0010;
        repeat (10) tick();
        check("halt_ignores_fetch", 80'(mem_en_cnt - base), 80'(1));
        check("halt_i_cnt", i_grant_cnt, 4'd0);
        halt = 1'b0; i_req = 1'b0;
        tick();
        check("halt_sticky", halted, 1'b1);
        do_reset();
        check("halt_cleared_by_rst", halted, 1'b0);

        // halt in IDLE beats a data request
        lat = 1;
        halt = 1'b1; d_req = 1'b1; d_addr = 16'h0020;
        tick();
        check("idle_halt_no_mem_en", mem_en, 1'b0);
        check("idle_halt_halted", halted, 1'b1);
        check("idle_halt_d_cnt", d_grant_cnt, 4'd0);
        do_reset();

        // reset during BUSY_I, stray mem_done afterwards
        lat = 3;
        base = mem_en_cnt;
        i_req = 1'b1; i_addr = 16'h0010;
        tick();
        tick();
        rst = 1'b1; i_req = 1'b0;
        tick();
        rst = 1'b0;
        check("rst_mid_outputs", outs, 0);
        check("rst_mid_state", dut.state_q, IDLE);
        repeat (6) tick();
        check("rst_stray_outputs", outs, 0);
        check("rst_stray_mem_en_count", 80'(mem_en_cnt - base), 80'(1));

        // 17 loads saturate a 4-bit counter; back-to-back spacing is 4 cycles
        do_reset();
        lat = 1;
        for (int k = 0; k < 17; k++) push(1, 0, 1, 16'hD00D);
        target = done_cnt + 17;
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0020;
        wait_dones(target, 100);
        d_req = 1'b0;
        repeat (3) tick();
        check("sat_d_cnt", d_grant_cnt, 4'hF);
        check("sat_i_cnt", i_grant_cnt, 4'h0);
        check("b2b_gap", 80'(last_gap), 80'(4));

        check("scoreboard_drained", 80'(exp_q.size()), 80'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
